// File: rtl/counter_pkg.sv
// Shared types and default widths for the up-counter timer block.
package counter_pkg;

    // Control FSM states; the 2-bit encoding is visible on debug taps.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W  = 16;
    localparam int WRAP_W = 8;

endpackage

// File: rtl/counter_up_core.sv
// Plain WIDTH-bit count register: load beats clear beats increment.
module counter_up_core #(
    parameter int WIDTH = 16
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic             inc,
    input  logic [WIDTH-1:0] ld_value,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Count register on the falling edge, cleared asynchronously by the active-low reset.
    always_ff @(negedge clock0 or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_value;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/counterup16_ctrl_negedge_async_resetn.sv
// Programmable up-counter timer: periodic or one-shot, with tc pulse,
// sticky done flag and a saturating wrap counter.
module counterup16_ctrl_negedge_async_resetn
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int WRAPW = WRAP_W
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             done,
    output logic [WRAPW-1:0] wraps
);

    localparam logic [WRAPW-1:0] WRAP_ONE = WRAPW'(1);
    localparam logic [WRAPW-1:0] WRAP_MAX = '1;

    state_t           state;
    state_t           state_n;
    logic             tc_n;
    logic [WRAPW-1:0] wraps_n;
    logic             core_clr;
    logic             core_ld;
    logic             core_inc;

    counter_up_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock0   (clock0),
        .reset    (reset),
        .clr      (core_clr),
        .ld       (core_ld),
        .inc      (core_inc),
        .ld_value (load_value),
        .count    (count)
    );

    // Next-state, register controls, tc and wrap count; priority load > stop > start > advance.
    always_comb begin
        state_n  = state;
        tc_n     = 1'b0;
        wraps_n  = wraps;
        core_clr = 1'b0;
        core_ld  = 1'b0;
        core_inc = 1'b0;

        if (load) begin
            core_ld = 1'b1;
            if (state == DONE) begin
                state_n = IDLE;
            end
        end else if (stop) begin
            // Stop also masks a simultaneous start, even when already idle or done.
            if (state == RUN) begin
                state_n = IDLE;
            end
        end else if (start) begin
            core_clr = 1'b1;
            state_n  = RUN;
            wraps_n  = '0;
        end else if (state == RUN) begin
            if (count != limit) begin
                core_inc = 1'b1;
            end else if (!mode) begin
                core_clr = 1'b1;
                tc_n     = 1'b1;
                if (wraps != WRAP_MAX) begin
                    wraps_n = wraps + WRAP_ONE;
                end
            end else begin
                state_n = DONE;
                tc_n    = 1'b1;
            end
        end
    end

    // State, tc pulse and wrap counter registers, all on the falling edge.
    always_ff @(negedge clock0 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tc    <= 1'b0;
            wraps <= '0;
        end else begin
            state <= state_n;
            tc    <= tc_n;
            wraps <= wraps_n;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_counterup16_ctrl_negedge_async_resetn.sv
// Directed self-checking bench for the up-counter timer.
module tb_counterup16_ctrl_negedge_async_resetn;

    logic        clock0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] limit;
    logic        mode;
    logic [15:0] count;
    logic        running;
    logic        tc;
    logic        done;
    logic [7:0]  wraps;

    int n_checks;
    int n_fail;

    counterup16_ctrl_negedge_async_resetn dut (
        .clock0     (clock0),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .load       (load),
        .load_value (load_value),
        .limit      (limit),
        .mode       (mode),
        .count      (count),
        .running    (running),
        .tc         (tc),
        .done       (done),
        .wraps      (wraps)
    );

    // Free-running clock; the active edge is the falling one.
    initial clock0 = 1'b1;
    always #5 clock0 = ~clock0;

    // Advance through one falling edge and park just after the next rising edge.
    task automatic tick();
        @(negedge clock0);
        @(posedge clock0);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic l,
                                 input logic [15:0] lv, input logic [15:0] lim,
                                 input logic m);
        start      = s;
        stop       = p;
        load       = l;
        load_value = lv;
        limit      = lim;
        mode       = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] c, input logic r,
                            input logic t, input logic d, input logic [7:0] w);
        checkOutput({tag, " count"},   32'(count),   32'(c));
        checkOutput({tag, " running"}, 32'(running), 32'(r));
        checkOutput({tag, " tc"},      32'(tc),      32'(t));
        checkOutput({tag, " done"},    32'(done),    32'(d));
        checkOutput({tag, " wraps"},   32'(wraps),   32'(w));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        #1;
        checkAll("por", 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset mid-RUN at 0x0123
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0123, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        checkAll("pre_reset", 16'h0123, 1'b1, 1'b0, 1'b0, 8'd0);
        #2;
        reset = 1'b0;
        #1;
        checkAll("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        reset = 1'b1;
        tick();
        checkAll("post_reset1", 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("post_reset2", 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);

        // Periodic, limit 3
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'd3, 1'b0);
        checkAll("per_start", 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkAll($sformatf("per_cyc%0d", i), 16'(i % 4), 1'b1,
                     (i % 4) == 0, 1'b0, 8'(i / 4));
        end
        for (int i = 13; i <= 1200; i++) begin
            tick();
        end
        checkAll("per_sat", 16'h0000, 1'b1, 1'b1, 1'b0, 8'd255);

        // One-shot, limit 5
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'd5, 1'b1);
        checkAll("os_start", 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkAll($sformatf("os_cyc%0d", i), 16'(i), 1'b1, 1'b0, 1'b0, 8'd0);
        end
        tick();
        checkAll("os_tc", 16'd5, 1'b0, 1'b1, 1'b1, 8'd0);
        tick();
        checkAll("os_hold1", 16'd5, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        checkAll("os_hold2", 16'd5, 1'b0, 1'b0, 1'b1, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'd5, 1'b1);
        tick();
        checkAll("os_restart", 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);

        // Load above limit, natural wrap gives no tc
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0001, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0);
        checkAll("ld_fffe", 16'hFFFE, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("ld_ffff", 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("ld_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("ld_one", 16'h0001, 1'b1, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("ld_tc", 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1);
        tick();
        checkAll("ld_after", 16'h0001, 1'b1, 1'b0, 1'b0, 8'd1);

        // start+stop together at count 7, then load+start together
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        checkAll("ss_pre", 16'd7, 1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        tick();
        checkAll("ss_stop", 16'd7, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0ABC, 16'hFFFF, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        checkAll("ld_start", 16'h0ABC, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        checkAll("ld_idle_hold", 16'h0ABC, 1'b0, 1'b0, 1'b0, 8'd0);

        // limit 0, periodic: tc every cycle, stop drops it
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkAll("z_start", 16'h0000, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkAll($sformatf("z_cyc%0d", i), 16'h0000, 1'b1, 1'b1, 1'b0, 8'(i));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkAll("z_stop", 16'h0000, 1'b0, 1'b0, 1'b0, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counterup16_ctrl_negedge_async_resetn.md
Name: counterup16_ctrl_negedge_async_resetn

Overview:
- Programmable 16-bit up counter, the counting-up counterpart to the down counters in the simple_registers/counters family.
- Counts on the falling edge of clock0 from 0 (or a loaded value) toward a programmable terminal value `limit`.
- Two modes: periodic (wrap to 0) and one-shot (stop at limit).
- Outputs are a terminal-count pulse, a sticky done flag and a saturating wrap counter, for use as a timer/tick source.

Parameters:
- WIDTH, 16, counter and limit width.
- WRAPW, 8, width of the saturating wrap counter.

Ports:
- clock0  input  1  counter clock; all state updates on negedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level sampled at negedge; clears count, enters RUN.
- stop  input  1  halts counting, holds count.
- load  input  1  loads load_value into count.
- load_value  input  WIDTH  value for load.
- limit  input  WIDTH  terminal value; sampled every edge, not latched.
- mode  input  1  0 = periodic, 1 = one-shot; sampled every edge.
- count  output  WIDTH  current count (registered).
- running  output  1  high while state is RUN.
- tc  output  1  one-cycle terminal-count pulse (registered).
- done  output  1  sticky one-shot completion flag.
- wraps  output  WRAPW  saturating number of periodic wraps since the last start.

Behaviour:
- **Reset (reset=0, asynchronous):** count=0, state=IDLE, running=0, tc=0, done=0, wraps=0. It takes effect immediately, including mid-RUN. The first update after release is the first negedge with reset=1.
- **State machine:** IDLE, RUN, DONE (encoded in 2 bits). running = (state==RUN). done = (state==DONE).
- **Priority at each negedge:** load > stop > start > count advance.
- **load:**
  - count <= load_value.
  - RUN stays RUN; DONE goes to IDLE; IDLE stays IDLE.
  - tc=0. wraps unchanged.
- **stop:**
  - RUN goes to IDLE with count held and tc=0.
  - No effect in IDLE or DONE.
- **start (from any state):** count <= 0, state <= RUN, wraps <= 0, tc=0.
- **RUN, count != limit:** count <= count+1 using modulo 2^WIDTH; 0xFFFF wraps naturally to 0x0000. tc=0.
- **RUN, count == limit, mode=0 (periodic):**
  - count <= 0 and tc=1 for exactly one cycle.
  - wraps <= wraps+1, saturating at 2^WRAPW-1.
  - State stays RUN.
- **RUN, count == limit, mode=1 (one-shot):** count holds limit, state <= DONE, tc=1 for one cycle.
- **IDLE and DONE:** count holds; tc=0.
- **Latency:**
  - tc is asserted in the cycle following the edge at which count == limit was observed.
  - After start, count reads 0 for one cycle, then 1.
  - A periodic period is therefore limit+1 cycles.
- **Boundary cases:**
  - limit=0, periodic: count stays 0 and tc is high every cycle.
  - limit=0, one-shot: DONE one edge after start.
  - load_value > limit: counts up through 0xFFFF, wraps to 0, and matches only at limit. No tc occurs on the natural wrap.
  - A change to limit mid-RUN takes effect on the next compare.
  - start and stop in the same cycle: stop wins, so a RUN counter goes to IDLE and an IDLE counter stays IDLE.

Decomposition:
- **Shared package counter_pkg:**
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default widths CNT_W=16 and WRAP_W=8.
- **Sub-module counter_up_core:** a WIDTH-bit register with clr, ld, inc inputs on negedge clock0 with asynchronous active-low reset. The control FSM, tc and wraps logic live in the top module.

Test Plan:
- Reset asserted mid-RUN at count=0x0123 → all outputs read 0 immediately. After release with start=0, count stays 0 and state stays IDLE.
- Periodic, limit=3, start pulse → count sequence 0,1,2,3,0,1…; tc high in each cycle where count returns to 0. After 3 periods wraps=3; after 300 periods wraps=255.
- One-shot, limit=5 → count 0…5, then holds 5; tc is a single pulse; done=1 and running=0 until the next start. Then start → count=0, done=0.
- load_value=0xFFFE, limit=0x0001, periodic, RUN → count FFFE, FFFF, 0000, 0001, 0000; tc is asserted only after 0001.
- start and stop asserted together while RUN at count=7 → IDLE, count holds 7. load=1 with start=1 at the same edge → count=load_value and start is ignored.
- limit=0, periodic → tc is continuously high while RUN and count stays 0. stop → tc drops on the next cycle.
